sbinit_tx_ctrl: RTL and testbench

SBINIT_TX_CTRL -- requirements
Module: sbinit_tx_ctrl

---
 rtl/sbinit_tx_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_sbinit_tx_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sbinit_tx_ctrl.sv
// SBINIT transmit-side controller: requests the sideband clock pattern, then exchanges
// the Out-of-Reset and done request/response messages with the link partner.
module sbinit_tx_ctrl #(
    parameter int SB_MSG_WIDTH        = 4,
    parameter int MSG_OUT_OF_RESET    = 1,
    parameter int MSG_DONE_REQ        = 2,
    parameter int MSG_DONE_RESP       = 3,
    parameter int TIMEOUT_CYCLES      = 1000,
    parameter int PATTERN_WINDOW      = 64,
    parameter int MAX_PATTERN_RETRIES = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_SBINIT_en,
    input  logic                    i_start_pattern_done,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    input  logic                    i_rx_valid,
    input  logic                    i_SB_Busy,
    output logic                    o_start_pattern_req,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
    output logic                    o_valid_tx,
    output logic                    o_SBINIT_end_tx,
    output logic                    o_SBINIT_error,
    output logic [2:0]              o_current_state
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WIN_W = $clog2(PATTERN_WINDOW + 1);
    localparam int RTY_W = $clog2(MAX_PATTERN_RETRIES + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PATTERN_WINDOW - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_PATTERN_RETRIES);

    localparam logic [SB_MSG_WIDTH-1:0] CODE_OOR  = SB_MSG_WIDTH'(MSG_OUT_OF_RESET);
    localparam logic [SB_MSG_WIDTH-1:0] CODE_DREQ = SB_MSG_WIDTH'(MSG_DONE_REQ);
    localparam logic [SB_MSG_WIDTH-1:0] CODE_DRSP = SB_MSG_WIDTH'(MSG_DONE_RESP);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PATTERN      = 3'd1,
        ST_OUT_OF_RESET = 3'd2,
        ST_DONE_REQ     = 3'd3,
        ST_END          = 3'd4,
        ST_ERROR        = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [WIN_W-1:0]        win_q, win_d;
    logic [RTY_W-1:0]        rty_q, rty_d;
    logic                    sent_q, sent_d;
    logic                    seen_q, seen_d;
    logic                    req_q, req_d;
    logic                    vld_q, vld_d;
    logic                    end_q, end_d;
    logic                    err_q, err_d;
    logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;

    logic                    tmo_at_max;
    logic [TMO_W-1:0]        tmo_inc;
    logic [SB_MSG_WIDTH-1:0] tx_code;
    logic [SB_MSG_WIDTH-1:0] rx_code;
    logic                    in_msg_state;

    always_comb begin
        tmo_at_max   = (tmo_q == TMO_LAST);
        tmo_inc      = tmo_at_max ? tmo_q : tmo_q + TMO_W'(1);
        in_msg_state = (state_q == ST_OUT_OF_RESET) || (state_q == ST_DONE_REQ);
        tx_code      = (state_q == ST_DONE_REQ) ? CODE_DREQ : CODE_OOR;
        rx_code      = (state_q == ST_DONE_REQ) ? CODE_DRSP : CODE_OOR;
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        win_d   = win_q;
        rty_d   = rty_q;
        sent_d  = sent_q;
        seen_d  = seen_q;
        req_d   = 1'b0;
        vld_d   = 1'b0;
        msg_d   = msg_q;
        end_d   = end_q;
        err_d   = err_q;

        if (!i_SBINIT_en) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
            win_d   = '0;
            rty_d   = '0;
            sent_d  = 1'b0;
            seen_d  = 1'b0;
            msg_d   = '0;
            end_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_PATTERN;
                    req_d   = 1'b1;
                    tmo_d   = '0;
                    win_d   = '0;
                    rty_d   = '0;
                end
                ST_PATTERN: begin
                    if (i_start_pattern_done) begin
                        state_d = ST_OUT_OF_RESET;
                        tmo_d   = '0;
                        win_d   = '0;
                        rty_d   = '0;
                        sent_d  = 1'b0;
                        seen_d  = 1'b0;
                    end else if ((win_q == WIN_LAST) && (rty_q == RTY_MAX)) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                        tmo_d   = '0;
                    end else if (tmo_at_max) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                        tmo_d   = '0;
                    end else if (win_q == WIN_LAST) begin
                        // Window expired with retries left: ask for the pattern again.
                        req_d = 1'b1;
                        rty_d = rty_q + RTY_W'(1);
                        win_d = '0;
                        tmo_d = tmo_inc;
                    end else begin
                        win_d = win_q + WIN_W'(1);
                        tmo_d = tmo_inc;
                    end
                end
                ST_OUT_OF_RESET, ST_DONE_REQ: begin
                    if (sent_q && seen_q) begin
                        state_d = (state_q == ST_DONE_REQ) ? ST_END : ST_DONE_REQ;
                        end_d   = (state_q == ST_DONE_REQ);
                        tmo_d   = '0;
                        sent_d  = 1'b0;
                        seen_d  = 1'b0;
                    end else if (tmo_at_max) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                        tmo_d   = '0;
                        sent_d  = 1'b0;
                        seen_d  = 1'b0;
                    end else begin
                        tmo_d = tmo_inc;
                        if (!sent_q && !i_SB_Busy) begin
                            vld_d  = 1'b1;
                            msg_d  = tx_code;
                            sent_d = 1'b1;
                        end
                        if (in_msg_state && i_rx_valid && (i_decoded_SB_msg == rx_code)) begin
                            seen_d = 1'b1;
                        end
                    end
                end
                ST_END: begin
                    end_d = 1'b1;
                end
                ST_ERROR: begin
                    err_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            win_q   <= '0;
            rty_q   <= '0;
            sent_q  <= 1'b0;
            seen_q  <= 1'b0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
            msg_q   <= '0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            win_q   <= win_d;
            rty_q   <= rty_d;
            sent_q  <= sent_d;
            seen_q  <= seen_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
            msg_q   <= msg_d;
            end_q   <= end_d;
            err_q   <= err_d;
        end
    end

    assign o_start_pattern_req = req_q;
    assign o_valid_tx          = vld_q;
    assign o_encoded_SB_msg_tx = msg_q;
    assign o_SBINIT_end_tx     = end_q;
    assign o_SBINIT_error      = err_q;
    assign o_current_state     = state_q;

endmodule

// File: tb/tb_sbinit_tx_ctrl.sv
// Directed bench for sbinit_tx_ctrl with hand-computed expectations.
module tb_sbinit_tx_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       pat_done;
    logic [3:0] rx_msg;
    logic       rx_valid;
    logic       busy;
    logic       pat_req;
    logic [3:0] tx_msg;
    logic       tx_valid;
    logic       end_tx;
    logic       err;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    sbinit_tx_ctrl dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_SBINIT_en          (en),
        .i_start_pattern_done (pat_done),
        .i_decoded_SB_msg     (rx_msg),
        .i_rx_valid           (rx_valid),
        .i_SB_Busy            (busy),
        .o_start_pattern_req  (pat_req),
        .o_encoded_SB_msg_tx  (tx_msg),
        .o_valid_tx           (tx_valid),
        .o_SBINIT_end_tx      (end_tx),
        .o_SBINIT_error       (err),
        .o_current_state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {req, valid, end, error, state[2:0], msg[3:0]}
    function automatic int outs();
        return int'({pat_req, tx_valid, end_tx, err, state, tx_msg});
    endfunction

    task automatic send_rx(input logic [3:0] code);
        rx_valid = 1'b1;
        rx_msg   = code;
        tick();
        rx_valid = 1'b0;
        rx_msg   = 4'd0;
    endtask

    initial begin
        int req_cnt;
        int req_at [4];
        int err_at;
        int bad;

        rst_n = 1'b0; en = 1'b0; pat_done = 1'b0; rx_msg = 4'd0; rx_valid = 1'b0; busy = 1'b0;
        #23;
        check("reset_outs", outs(), 0);
        rst_n = 1'b1;
        tick();
        check("idle_en_low", outs(), 0);

        // Normal flow
        en = 1'b1;
        tick();
        check("nf_state_pattern", state, 1);
        check("nf_req_pulse", pat_req, 1);
        tick();
        check("nf_req_drop", pat_req, 0);
        repeat (7) tick();
        pat_done = 1'b1;
        tick();
        pat_done = 1'b0;
        check("nf_state_oor", state, 2);
        check("nf_no_valid_entry", tx_valid, 0);
        tick();
        check("nf_send1", {tx_valid, tx_msg}, {1'b1, 4'd1});
        tick();
        check("nf_send1_hold", {tx_valid, tx_msg}, {1'b0, 4'd1});
        send_rx(4'd1);
        check("nf_still_oor", state, 2);
        tick();
        check("nf_state_dreq", state, 3);
        tick();
        check("nf_send2", {tx_valid, tx_msg}, {1'b1, 4'd2});
        send_rx(4'd3);
        check("nf_dreq_wait", state, 3);
        tick();
        check("nf_end", {state, end_tx}, {3'd4, 1'b1});
        repeat (3) tick();
        check("nf_end_hold", {state, end_tx, tx_valid, pat_req}, {3'd4, 1'b1, 1'b0, 1'b0});
        en = 1'b0;
        tick();
        check("nf_en_drop", outs(), 0);

        // Partner first, busy hold-off
        busy = 1'b1;
        en = 1'b1;
        tick();
        pat_done = 1'b1;
        tick();
        pat_done = 1'b0;
        check("pf_state_oor", state, 2);
        send_rx(4'd1);
        bad = 0;
        repeat (4) begin
            if (tx_valid !== 1'b0 || state !== 3'd2) bad++;
            tick();
        end
        check("pf_busy_holdoff", bad, 0);
        busy = 1'b0;
        tick();
        check("pf_send_after_busy", {tx_valid, tx_msg, state}, {1'b1, 4'd1, 3'd2});
        tick();
        check("pf_state_dreq", {state, tx_valid}, {3'd3, 1'b0});

        // Timeout in DONE_REQ with a wrong code
        err_at = -1;
        for (int i = 1; i <= 1100; i++) begin
            if (i == 5) begin
                rx_valid = 1'b1;
                rx_msg   = 4'd2;
            end else begin
                rx_valid = 1'b0;
                rx_msg   = 4'd0;
            end
            tick();
            if (i == 1) check("to_send2", {tx_valid, tx_msg}, {1'b1, 4'd2});
            if (i == 500) check("to_wrong_code_ignored", state, 3);
            if (state == 3'd5) begin
                err_at = i;
                break;
            end
        end
        check("to_error_cycle", err_at, 1000);
        check("to_error_flag", err, 1);
        repeat (3) tick();
        check("to_error_hold", {state, err, tx_valid, pat_req}, {3'd5, 1'b1, 1'b0, 1'b0});
        en = 1'b0;
        tick();
        check("to_en_drop", outs(), 0);

        // Pattern retry exhaustion
        en = 1'b1;
        req_cnt = 0;
        err_at  = -1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (pat_req) begin
                if (req_cnt < 4) req_at[req_cnt] = i;
                req_cnt++;
            end
            if (state == 3'd5) begin
                err_at = i;
                break;
            end
        end
        check("pr_req_count", req_cnt, 4);
        check("pr_req0", req_at[0], 1);
        check("pr_req1", req_at[1], 65);
        check("pr_req2", req_at[2], 129);
        check("pr_req3", req_at[3], 193);
        check("pr_error_cycle", err_at, 257);
        check("pr_error_flag", err, 1);
        en = 1'b0;
        tick();

        // Same-cycle send/receive, en drop in DONE_REQ, restart
        en = 1'b1;
        tick();
        pat_done = 1'b1;
        tick();
        pat_done = 1'b0;
        send_rx(4'd1);
        check("sc_send_with_rx", {tx_valid, tx_msg, state}, {1'b1, 4'd1, 3'd2});
        tick();
        check("sc_state_dreq", state, 3);
        tick();
        check("sc_send2", tx_valid, 1);
        en = 1'b0;
        tick();
        check("ed_idle_all_zero", outs(), 0);
        en = 1'b1;
        tick();
        check("ed_restart", {state, pat_req}, {3'd1, 1'b1});

        // Async reset mid-DONE_REQ
        pat_done = 1'b1;
        tick();
        pat_done = 1'b0;
        send_rx(4'd1);
        tick();
        tick();
        tick();
        check("ar_before_reset", {state, tx_msg}, {3'd3, 4'd2});
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_async_clear", outs(), 0);
        #10;
        rst_n = 1'b1;
        en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
